// File: rtl/insn_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The request side carries decoded fields plus a 32-bit immediate; the
// response side carries one encoded instruction word per beat.
interface insn_encoder_if;
    // request side
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    // response side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        out_err;
    logic        out_last;

    // producer of requests / consumer of encoded words
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_insn, out_err, out_last
    );

    // the encoder itself
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_insn, out_err, out_last
    );
endinterface

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: scatters a 32-bit immediate into the I/S/B/U/J
// bit positions, range-checks it, and expands LI pseudo-requests into
// LUI (+ ADDI) sequences. One registered output stage with ready/valid.
module insn_encoder #(
    parameter bit ZERO_ON_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    insn_encoder_if.slave bus
);
    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

    typedef enum logic {IDLE, LO_PEND} state_t;

    state_t      state_q,     state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_insn_q,  out_insn_d;
    logic        out_err_q,   out_err_d;
    logic        out_last_q,  out_last_d;
    logic [4:0]  pend_rd_q,   pend_rd_d;
    logic [11:0] pend_lo_q,   pend_lo_d;

    // combinational encoding of the current request
    logic [31:0] enc_insn;
    logic        enc_err;
    logic        enc_last;
    logic        enc_pend;

    logic        fits_12;
    logic        fits_13;
    logic        fits_21;
    logic [19:0] li_hi;
    logic        load_en;
    logic        in_ready;

    // A value fits an N-bit signed field when all bits above N-1 copy the sign.
    assign fits_12 = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
    assign fits_13 = (&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]);
    assign fits_21 = (&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]);

    // (imm + 0x800) >> 12: the +0x800 only ever carries into bit 12 when
    // imm[11] is set, so the upper half is just imm[31:12] + imm[11].
    assign li_hi = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

    // The output stage can take a new word when it is empty or being drained.
    assign load_en  = ~out_valid_q | bus.out_ready;
    assign in_ready = (state_q == IDLE) & load_en;

    // Scatter the immediate for the requested format and flag range errors.
    always_comb begin
        enc_insn = 32'h0;
        enc_err  = 1'b0;
        enc_last = 1'b1;
        enc_pend = 1'b0;
        case (bus.in_fmt)
            FMT_R: begin
                enc_insn = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            FMT_I: begin
                enc_insn = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
                enc_err  = ~fits_12;
            end
            FMT_S: begin
                enc_insn = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:0], bus.in_opcode};
                enc_err  = ~fits_12;
            end
            FMT_B: begin
                enc_insn = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                            bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                            bus.in_imm[11], bus.in_opcode};
                enc_err  = ~fits_13 | bus.in_imm[0];
            end
            FMT_U: begin
                enc_insn = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
                enc_err  = |bus.in_imm[11:0];
            end
            FMT_J: begin
                enc_insn = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                            bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
                enc_err  = ~fits_21 | bus.in_imm[0];
            end
            FMT_LI: begin
                if (fits_12) begin
                    // ADDI rd, x0, imm
                    enc_insn = {bus.in_imm[11:0], 5'd0, 3'b000,
                                bus.in_rd, OPCODE_OP_IMM};
                end else begin
                    // LUI rd, hi; the ADDI follows only if the low part is non-zero
                    enc_insn = {li_hi, bus.in_rd, OPCODE_LUI};
                    if (bus.in_imm[11:0] != 12'd0) begin
                        enc_last = 1'b0;
                        enc_pend = 1'b1;
                    end
                end
            end
            default: begin
                // reserved format has no meaningful encoding: emit zero
                enc_insn = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
        if (ZERO_ON_ERR && enc_err) begin
            enc_insn = 32'h0;
        end
    end

    // Next-state: finish a pending LI ADDI first, otherwise accept a request,
    // otherwise drop out_valid once the held word has drained.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_insn_d  = out_insn_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        pend_rd_d   = pend_rd_q;
        pend_lo_d   = pend_lo_q;
        if (state_q == LO_PEND) begin
            if (load_en) begin
                // ADDI rd, rd, lo
                out_valid_d = 1'b1;
                out_insn_d  = {pend_lo_q, pend_rd_q, 3'b000, pend_rd_q, OPCODE_OP_IMM};
                out_err_d   = 1'b0;
                out_last_d  = 1'b1;
                state_d     = IDLE;
            end
        end else if (bus.in_valid && in_ready) begin
            out_valid_d = 1'b1;
            out_insn_d  = enc_insn;
            out_err_d   = enc_err;
            out_last_d  = enc_last;
            if (enc_pend) begin
                state_d   = LO_PEND;
                pend_rd_d = bus.in_rd;
                pend_lo_d = bus.in_imm[11:0];
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output register; reset drops any pending ADDI.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_insn_q  <= 32'h0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            pend_rd_q   <= 5'd0;
            pend_lo_q   <= 12'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
            pend_rd_q   <= pend_rd_d;
            pend_lo_q   <= pend_lo_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_insn  = out_insn_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: expected words are queued when a request
// is accepted and compared when the encoder hands a word to the consumer.
module tb_insn_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    insn_encoder_if ifc ();

    insn_encoder #(.ZERO_ON_ERR(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic [31:0] insn;
        logic        err;
        logic        last;
        logic        chk_imm;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // independent immediate extractor used to check the random sweep
    function automatic logic [31:0] immext(input logic [2:0] f, input logic [31:0] i);
        case (f)
            3'd1:    return {{20{i[31]}}, i[31:20]};
            3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    return {i[31:12], 12'd0};
            3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic push_word(input logic [31:0] insn, input logic err, input logic last);
        exp_t e;
        e = '0;
        e.insn = insn; e.err = err; e.last = last;
        sb.push_back(e);
    endtask

    task automatic push_imm(input logic [2:0] fmt, input logic [31:0] imm, input logic [6:0] op);
        exp_t e;
        e = '0;
        e.chk_imm = 1'b1; e.fmt = fmt; e.imm = imm; e.op = op; e.last = 1'b1;
        sb.push_back(e);
    endtask

    // consumer side: compare every word that actually transfers
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_word got insn=%08h, required none", ifc.out_insn);
            end else begin
                n_pass++;
                e = sb.pop_front();
                if (e.chk_imm) begin
                    n_total++;
                    if (immext(e.fmt, ifc.out_insn) !== e.imm)
                        $display("FAIL rand_immext fmt=%0d got %08h required %08h (insn %08h)",
                                 e.fmt, immext(e.fmt, ifc.out_insn), e.imm, ifc.out_insn);
                    else n_pass++;
                    n_total++;
                    if (ifc.out_insn[6:0] !== e.op)
                        $display("FAIL rand_opcode got %02h required %02h", ifc.out_insn[6:0], e.op);
                    else n_pass++;
                end else begin
                    n_total++;
                    if (ifc.out_insn !== e.insn)
                        $display("FAIL word_insn got %08h required %08h", ifc.out_insn, e.insn);
                    else n_pass++;
                end
                n_total++;
                if (ifc.out_err !== e.err || ifc.out_last !== e.last)
                    $display("FAIL word_flags got err=%b last=%b required err=%b last=%b",
                             ifc.out_err, ifc.out_last, e.err, e.last);
                else n_pass++;
            end
        end
    end

    // drive one request and hold it until accepted (bounded)
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, output int waits);
        ifc.in_valid = 1'b1; ifc.in_fmt = fmt; ifc.in_opcode = op; ifc.in_rd = rd;
        ifc.in_rs1 = rs1; ifc.in_rs2 = rs2; ifc.in_funct3 = f3; ifc.in_funct7 = f7;
        ifc.in_imm = imm;
        waits = 0;
        @(negedge clk);
        while (!ifc.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ifc.in_ready) begin
            n_total++;
            $display("FAIL send_timeout got in_ready=0 after %0d cycles, required 1", waits);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL drain got %0d pending words, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0; ifc.in_fmt = '0; ifc.in_opcode = '0; ifc.in_rd = '0;
        ifc.in_rs1 = '0; ifc.in_rs2 = '0; ifc.in_funct3 = '0; ifc.in_funct7 = '0;
        ifc.in_imm = '0; ifc.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (ifc.out_valid !== 1'b0 || ifc.out_insn !== 32'h0 || ifc.out_err !== 1'b0 ||
            ifc.out_last !== 1'b0)
            $display("FAIL reset_outputs got v=%b insn=%08h err=%b last=%b required 0/0/0/0",
                     ifc.out_valid, ifc.out_insn, ifc.out_err, ifc.out_last);
        else n_pass++;
        n_total++;
        if (ifc.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", ifc.in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_formats();
        int w;
        // I with latency check
        push_word(32'hFFF10093, 1'b0, 1'b1);
        send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, w);
        @(negedge clk);
        n_total++;
        if (ifc.out_valid !== 1'b1) $display("FAIL i_latency got out_valid=%b required 1", ifc.out_valid);
        else n_pass++;
        @(posedge clk); #1;
        push_word(32'h002081B3, 1'b0, 1'b1);                   // add x3,x1,x2
        send(3'd0, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, w);
        push_word(32'hFE20AC23, 1'b0, 1'b1);                   // sw x2,-8(x1)
        send(3'd2, OP_ST, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFF8, w);
        push_word(32'hFE208EE3, 1'b0, 1'b1);                   // beq x1,x2,-4
        send(3'd3, OP_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, w);
        wait_drain();
    endtask

    task automatic test_range_errors();
        int w;
        push_word(32'h00208163, 1'b1, 1'b1);                   // B misaligned imm=3
        send(3'd3, OP_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, w);
        push_word(32'h80010093, 1'b1, 1'b1);                   // I imm=2048 too big
        send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, w);
        push_imm(3'd1, 32'hFFFFF800, OP_IMM);                  // I imm=-2048 edge
        send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, w);
        push_word(32'h123452B7, 1'b1, 1'b1);                   // U low bits set
        send(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, w);
        push_imm(3'd5, 32'h000FFFFE, OP_JAL);                  // J max
        send(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FFFFE, w);
        push_word(32'h800000EF, 1'b1, 1'b1);                   // J 2^20 too big
        send(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, w);
        push_imm(3'd3, 32'hFFFFF000, OP_BR);                   // B min -4096
        send(3'd3, OP_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000, w);
        push_word(32'h00000000, 1'b1, 1'b1);                   // reserved fmt
        send(3'd7, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, w);
        wait_drain();
    endtask

    task automatic test_li();
        int w;
        push_word(32'h123462B7, 1'b0, 1'b0);
        push_word(32'hFFF28293, 1'b0, 1'b1);
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, w);
        @(negedge clk);
        n_total++;
        if (ifc.in_ready !== 1'b0) $display("FAIL li_ready_lo_pend got %b required 0", ifc.in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ifc.in_ready !== 1'b1) $display("FAIL li_ready_after got %b required 1", ifc.in_ready);
        else n_pass++;
        @(posedge clk); #1;
        push_word(32'h000012B7, 1'b0, 1'b1);                   // LUI only
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, w);
        push_word(32'h06400293, 1'b0, 1'b1);                   // small ADDI
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100, w);
        push_word(32'h80000293, 1'b0, 1'b1);                   // -2048 fits ADDI
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, w);
        push_word(32'hFFFFF2B7, 1'b0, 1'b1);                   // -4096 LUI only
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, w);
        wait_drain();
    endtask

    task automatic test_stall();
        int w;
        ifc.out_ready = 1'b0;
        push_word(32'hFFF10093, 1'b0, 1'b1);
        send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, w);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if (ifc.out_valid !== 1'b1 || ifc.out_insn !== 32'hFFF10093 || ifc.in_ready !== 1'b0)
                $display("FAIL stall_hold c%0d got v=%b insn=%08h rdy=%b required 1/FFF10093/0",
                         c, ifc.out_valid, ifc.out_insn, ifc.in_ready);
            else n_pass++;
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_lo_pend();
        int w;
        ifc.out_ready = 1'b0;
        push_word(32'h123462B7, 1'b0, 1'b0);
        push_word(32'hFFF28293, 1'b0, 1'b1);
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, w);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if (ifc.out_valid !== 1'b0) $display("FAIL rst_lo_pend c%0d got out_valid=%b required 0",
                                                 c, ifc.out_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls = 0;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  op;
        ifc.out_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            fmt = 3'($urandom_range(1, 5));
            case (fmt)
                3'd1, 3'd2: imm = {{20{1'b0}}, 12'($urandom_range(0, 4095))};
                3'd3:       imm = {{19{1'b0}}, 13'($urandom_range(0, 8191))};
                3'd4:       imm = $urandom & 32'hFFFFF000;
                default:    imm = {{11{1'b0}}, 21'($urandom_range(0, 2097151))};
            endcase
            case (fmt)
                3'd1, 3'd2: imm = {{20{imm[11]}}, imm[11:0]};
                3'd3:       imm = {{19{imm[12]}}, imm[12:1], 1'b0};
                3'd5:       imm = {{11{imm[20]}}, imm[20:1], 1'b0};
                default:    imm = imm;
            endcase
            op = 7'($urandom);
            push_imm(fmt, imm, op);
            send(fmt, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'd0, imm, w);
            stalls += w;
        end
        n_total++;
        if (stalls != 0) $display("FAIL throughput got %0d stall cycles required 0", stalls);
        else n_pass++;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_formats();
        test_range_errors();
        test_li();
        test_stall();
        test_reset_lo_pend();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
